// File: rtl/cnt_seq_monitor.sv
// Receive-side checker for an up-counting bus: locks onto the +1 sequence,
// then flags and counts every qualified sample that departs from it.
module cnt_seq_monitor #(
    parameter int W      = 8,
    parameter int LOCK_N = 4,
    parameter int LOSS_N = 3,
    parameter int ERR_W  = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_restart,
    input  logic [W-1:0]     i_cnt_in,
    input  logic             i_clr_err,
    output logic             o_locked,
    output logic             o_err,
    output logic [ERR_W-1:0] o_err_cnt,
    output logic [W-1:0]     o_exp_out
);

    // state    | meaning
    // S_HUNT   | no reference; next qualified sample seeds prev
    // S_VERIFY | counting consecutive in-sequence samples toward lock
    // S_TRACK  | locked; every sample compared against r_exp

    localparam int RUN_W  = $clog2(LOCK_N + 1);
    localparam int MISS_W = $clog2(LOSS_N + 1);

    typedef enum logic [1:0] {
        S_HUNT   = 2'd0,
        S_VERIFY = 2'd1,
        S_TRACK  = 2'd2
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [W-1:0]        r_prev, w_prev_nxt;
    logic [RUN_W-1:0]    r_run, w_run_nxt;
    logic [MISS_W-1:0]   r_miss, w_miss_nxt;
    logic [W-1:0]        r_exp, w_exp_nxt;
    logic                r_err, w_err_nxt;
    logic [ERR_W-1:0]    r_err_cnt, w_err_cnt_nxt;

    logic [W-1:0]        w_prev_inc;
    logic [W-1:0]        w_e;
    logic                w_in_seq;
    logic                w_mismatch;
    logic [RUN_W-1:0]    w_run_inc;
    logic [MISS_W-1:0]   w_miss_inc;

    assign w_prev_inc = r_prev + W'(1);
    assign w_in_seq   = (i_cnt_in == w_prev_inc) || (i_restart && (i_cnt_in == '0));
    assign w_e        = i_restart ? '0 : r_exp;
    assign w_mismatch = i_en && (r_state == S_TRACK) && (i_cnt_in != w_e);
    assign w_run_inc  = r_run + RUN_W'(1);
    assign w_miss_inc = r_miss + MISS_W'(1);

    always_comb begin
        w_state_nxt   = r_state;
        w_prev_nxt    = r_prev;
        w_run_nxt     = r_run;
        w_miss_nxt    = r_miss;
        w_exp_nxt     = r_exp;
        w_err_nxt     = 1'b0;
        w_err_cnt_nxt = r_err_cnt;

        if (i_en) begin
            unique case (r_state)
                S_HUNT: begin
                    w_prev_nxt  = i_cnt_in;
                    w_run_nxt   = RUN_W'(1);
                    w_state_nxt = S_VERIFY;
                end
                S_VERIFY: begin
                    w_prev_nxt = i_cnt_in;
                    if (w_in_seq) begin
                        w_run_nxt = w_run_inc;
                        if (w_run_inc == RUN_W'(LOCK_N)) begin
                            w_state_nxt = S_TRACK;
                            w_miss_nxt  = '0;
                            w_exp_nxt   = i_cnt_in + W'(1);
                        end
                    end else begin
                        w_run_nxt = RUN_W'(1);
                    end
                end
                S_TRACK: begin
                    // Expectation always advances from e, never resyncs to a bad sample.
                    w_exp_nxt = w_e + W'(1);
                    if (w_mismatch) begin
                        w_err_nxt  = 1'b1;
                        w_miss_nxt = w_miss_inc;
                        if (w_miss_inc == MISS_W'(LOSS_N)) begin
                            w_state_nxt = S_HUNT;
                            w_exp_nxt   = '0;
                            w_miss_nxt  = '0;
                            w_run_nxt   = '0;
                        end
                    end else begin
                        w_miss_nxt = '0;
                    end
                end
                default: w_state_nxt = S_HUNT;
            endcase
        end

        if (i_clr_err) begin
            w_err_cnt_nxt = w_mismatch ? ERR_W'(1) : '0;
        end else if (w_mismatch && (r_err_cnt != '1)) begin
            w_err_cnt_nxt = r_err_cnt + ERR_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_HUNT;
            r_prev    <= '0;
            r_run     <= '0;
            r_miss    <= '0;
            r_exp     <= '0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_prev    <= w_prev_nxt;
            r_run     <= w_run_nxt;
            r_miss    <= w_miss_nxt;
            r_exp     <= w_exp_nxt;
            r_err     <= w_err_nxt;
            r_err_cnt <= w_err_cnt_nxt;
        end
    end

    assign o_locked  = (r_state == S_TRACK);
    assign o_err     = r_err;
    assign o_err_cnt = r_err_cnt;
    assign o_exp_out = r_exp;

endmodule

// File: tb/tb_cnt_seq_monitor.sv
// Directed bench for cnt_seq_monitor; a second instance with a 2-bit error
// counter shares the stimulus to exercise saturation.
module tb_cnt_seq_monitor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        restart = 1'b0;
    logic [7:0]  cnt_in = '0;
    logic        clr_err = 1'b0;

    logic        locked, err;
    logic [15:0] err_cnt;
    logic [7:0]  exp_out;
    logic        locked2, err2;
    logic [1:0]  err_cnt2;
    logic [7:0]  exp_out2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cnt_seq_monitor #(.W(8), .LOCK_N(4), .LOSS_N(3), .ERR_W(16)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_restart(restart),
        .i_cnt_in(cnt_in), .i_clr_err(clr_err),
        .o_locked(locked), .o_err(err), .o_err_cnt(err_cnt), .o_exp_out(exp_out)
    );

    cnt_seq_monitor #(.W(8), .LOCK_N(4), .LOSS_N(3), .ERR_W(2)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_restart(restart),
        .i_cnt_in(cnt_in), .i_clr_err(clr_err),
        .o_locked(locked2), .o_err(err2), .o_err_cnt(err_cnt2), .o_exp_out(exp_out2)
    );

    // One qualified/unqualified cycle; outputs are sampled 1ns after the edge.
    task automatic drive(input logic e, input logic rs, input logic [7:0] c, input logic clr);
        en = e; restart = rs; cnt_in = c; clr_err = clr;
        @(posedge clk);
        #1;
        en = 1'b0; restart = 1'b0; clr_err = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (locked !== 1'b0 || err !== 1'b0 || err_cnt !== 16'd0 || exp_out !== 8'd0) begin
            n_errors++;
            $display("FAIL reset_state locked=%b err=%b err_cnt=%0d exp=%0d want 0/0/0/0",
                     locked, err, err_cnt, exp_out);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_lock();
        for (int i = 10; i <= 12; i++) begin
            drive(1'b1, 1'b0, 8'(i), 1'b0);
            n_checks++;
            if (locked !== 1'b0) begin
                n_errors++;
                $display("FAIL lock_early sample=%0d locked=%b want 0", i, locked);
            end
        end
        drive(1'b1, 1'b0, 8'd13, 1'b0);
        n_checks++;
        if (locked !== 1'b1 || exp_out !== 8'd14 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL lock locked=%b exp=%0d err=%b want 1/14/0", locked, exp_out, err);
        end
    endtask

    task automatic test_wrap_gaps();
        int bad;
        bad = 0;
        rst_n = 1'b0; #2; rst_n = 1'b1;
        for (int i = 250; i <= 253; i++) drive(1'b1, 1'b0, 8'(i), 1'b0);
        n_checks++;
        if (locked !== 1'b1 || exp_out !== 8'd254) begin
            n_errors++;
            $display("FAIL wrap_lock locked=%b exp=%0d want 1/254", locked, exp_out);
        end
        drive(1'b1, 1'b0, 8'd254, 1'b0); if (err !== 1'b0 || locked !== 1'b1) bad++;
        drive(1'b1, 1'b0, 8'd255, 1'b0); if (err !== 1'b0 || locked !== 1'b1) bad++;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 8'd77, 1'b0);
            if (err !== 1'b0 || locked !== 1'b1 || exp_out !== 8'd0) bad++;
        end
        drive(1'b1, 1'b0, 8'd0, 1'b0); if (err !== 1'b0 || locked !== 1'b1) bad++;
        drive(1'b1, 1'b0, 8'd1, 1'b0); if (err !== 1'b0 || locked !== 1'b1) bad++;
        n_checks++;
        if (bad != 0 || exp_out !== 8'd2 || err_cnt !== 16'd0) begin
            n_errors++;
            $display("FAIL wrap_gaps bad_cycles=%0d exp=%0d err_cnt=%0d want 0/2/0", bad, exp_out, err_cnt);
        end
    endtask

    task automatic test_glitch();
        for (int i = 2; i <= 19; i++) drive(1'b1, 1'b0, 8'(i), 1'b0);
        n_checks++;
        if (exp_out !== 8'd20 || err_cnt !== 16'd0) begin
            n_errors++;
            $display("FAIL glitch_setup exp=%0d err_cnt=%0d want 20/0", exp_out, err_cnt);
        end
        drive(1'b1, 1'b0, 8'd25, 1'b0);
        n_checks++;
        if (err !== 1'b1 || err_cnt !== 16'd1 || locked !== 1'b1 || exp_out !== 8'd21) begin
            n_errors++;
            $display("FAIL glitch_err err=%b err_cnt=%0d locked=%b exp=%0d want 1/1/1/21",
                     err, err_cnt, locked, exp_out);
        end
        drive(1'b1, 1'b0, 8'd21, 1'b0);
        n_checks++;
        if (err !== 1'b0 || exp_out !== 8'd22) begin
            n_errors++;
            $display("FAIL glitch_accept21 err=%b exp=%0d want 0/22", err, exp_out);
        end
        drive(1'b1, 1'b0, 8'd22, 1'b0);
        n_checks++;
        if (err !== 1'b0 || err_cnt !== 16'd1 || locked !== 1'b1 || exp_out !== 8'd23) begin
            n_errors++;
            $display("FAIL glitch_accept22 err=%b err_cnt=%0d locked=%b exp=%0d want 0/1/1/23",
                     err, err_cnt, locked, exp_out);
        end
    endtask

    task automatic test_back_to_back_loss();
        logic [7:0] want_exp [3];
        want_exp[0] = 8'd41; want_exp[1] = 8'd42; want_exp[2] = 8'd0;
        for (int i = 23; i <= 38; i++) drive(1'b1, 1'b0, 8'(i), 1'b0);
        drive(1'b1, 1'b0, 8'd39, 1'b1);
        n_checks++;
        if (err_cnt !== 16'd0 || exp_out !== 8'd40 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL clr_on_match err_cnt=%0d exp=%0d err=%b want 0/40/0", err_cnt, exp_out, err);
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 8'd99, 1'b0);
            n_checks++;
            if (err !== 1'b1 || err_cnt !== 16'(k + 1) || locked !== (k < 2) || exp_out !== want_exp[k]) begin
                n_errors++;
                $display("FAIL loss_miss%0d err=%b err_cnt=%0d locked=%b exp=%0d want 1/%0d/%b/%0d",
                         k, err, err_cnt, locked, exp_out, k + 1, (k < 2), want_exp[k]);
            end
        end
        for (int i = 50; i <= 52; i++) drive(1'b1, 1'b0, 8'(i), 1'b0);
        n_checks++;
        if (locked !== 1'b0 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL relock_early locked=%b err=%b want 0/0", locked, err);
        end
        drive(1'b1, 1'b0, 8'd53, 1'b0);
        n_checks++;
        if (locked !== 1'b1 || exp_out !== 8'd54 || err_cnt !== 16'd3 || err_cnt2 !== 2'd3) begin
            n_errors++;
            $display("FAIL relock locked=%b exp=%0d err_cnt=%0d err_cnt2=%0d want 1/54/3/3",
                     locked, exp_out, err_cnt, err_cnt2);
        end
    endtask

    task automatic test_restart();
        for (int i = 54; i <= 56; i++) drive(1'b1, 1'b0, 8'(i), 1'b0);
        drive(1'b1, 1'b1, 8'd0, 1'b0);
        n_checks++;
        if (err !== 1'b0 || exp_out !== 8'd1 || locked !== 1'b1 || err_cnt !== 16'd3) begin
            n_errors++;
            $display("FAIL restart err=%b exp=%0d locked=%b err_cnt=%0d want 0/1/1/3",
                     err, exp_out, locked, err_cnt);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] want2 [5];
        want2[0] = 2'd1; want2[1] = 2'd2; want2[2] = 2'd3; want2[3] = 2'd3; want2[4] = 2'd3;
        drive(1'b1, 1'b0, 8'd1, 1'b1);
        n_checks++;
        if (err_cnt !== 16'd0 || err_cnt2 !== 2'd0) begin
            n_errors++;
            $display("FAIL sat_clear err_cnt=%0d err_cnt2=%0d want 0/0", err_cnt, err_cnt2);
        end
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b0, 8'd200, 1'b0);
            n_checks++;
            if (err2 !== 1'b1 || err_cnt2 !== want2[k] || err_cnt !== 16'(k + 1)) begin
                n_errors++;
                $display("FAIL sat_err%0d err2=%b err_cnt2=%0d err_cnt=%0d want 1/%0d/%0d",
                         k, err2, err_cnt2, err_cnt, want2[k], k + 1);
            end
            drive(1'b1, 1'b0, 8'(3 + 2 * k), 1'b0);
        end
        n_checks++;
        if (locked2 !== 1'b1 || exp_out2 !== 8'd12 || err_cnt2 !== 2'd3) begin
            n_errors++;
            $display("FAIL sat_end locked2=%b exp2=%0d err_cnt2=%0d want 1/12/3", locked2, exp_out2, err_cnt2);
        end
    endtask

    task automatic test_clr_with_mismatch();
        drive(1'b1, 1'b0, 8'd150, 1'b1);
        n_checks++;
        if (err !== 1'b1 || err_cnt !== 16'd1 || err_cnt2 !== 2'd1 || exp_out !== 8'd13) begin
            n_errors++;
            $display("FAIL clr_mismatch err=%b err_cnt=%0d err_cnt2=%0d exp=%0d want 1/1/1/13",
                     err, err_cnt, err_cnt2, exp_out);
        end
        drive(1'b1, 1'b0, 8'd13, 1'b0);
        n_checks++;
        if (err !== 1'b0 || err_cnt !== 16'd1 || exp_out !== 8'd14) begin
            n_errors++;
            $display("FAIL post_clr err=%b err_cnt=%0d exp=%0d want 0/1/14", err, err_cnt, exp_out);
        end
    endtask

    task automatic test_reset_midstream();
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (locked !== 1'b0 || err !== 1'b0 || err_cnt !== 16'd0 || exp_out !== 8'd0) begin
            n_errors++;
            $display("FAIL async_reset locked=%b err=%b err_cnt=%0d exp=%0d want 0/0/0/0",
                     locked, err, err_cnt, exp_out);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 5; i <= 7; i++) drive(1'b1, 1'b0, 8'(i), 1'b0);
        n_checks++;
        if (locked !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_relock_early locked=%b want 0", locked);
        end
        drive(1'b1, 1'b0, 8'd8, 1'b0);
        n_checks++;
        if (locked !== 1'b1 || exp_out !== 8'd9) begin
            n_errors++;
            $display("FAIL reset_relock locked=%b exp=%0d want 1/9", locked, exp_out);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_wrap_gaps();
        test_glitch();
        test_back_to_back_loss();
        test_restart();
        test_saturation();
        test_clr_with_mismatch();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cnt_seq_monitor.md
# cnt_seq_monitor

Receive-side checker for the free-running counter bus driven by our counter blocks (up-count by 1 per clock, synchronous clear to 0). It samples the counter bus on qualified cycles, locks onto the sequence, and then flags every sample that departs from the expected `previous + 1` value. It sits next to a counter instance in the test/debug fabric and feeds error status to software-visible registers.

## Interface
- `W`, default 8: counter bus width.
- `LOCK_N`, default 4: consecutive in-sequence samples required to lock (≥2).
- `LOSS_N`, default 3: consecutive mismatches while locked that drop lock (≥1).
- `ERR_W`, default 16: error counter width.

- `clk`, input, 1: clock, all state rising-edge.
- `rst`, input, 1: reset, asynchronous, active-low.
- `en`, input, 1: sample qualifier. `cnt_in` is only examined when high.
- `restart`, input, 1: producer clear indication. When high with `en`, the sample must equal 0.
- `cnt_in`, input, W: observed counter value.
- `clr_err`, input, 1: synchronous clear of `err_cnt`.
- `locked`, output, 1: monitor is in TRACK.
- `err`, output, 1: one-cycle pulse for each mismatching sample in TRACK.
- `err_cnt`, output, ERR_W: saturating mismatch count.
- `exp_out`, output, W: next expected value in TRACK, 0 otherwise.

## Operation
- States: HUNT, VERIFY, TRACK. Internal registers: `prev` (W), `run` (count up to LOCK_N), `miss` (count up to LOSS_N).
- All arithmetic is modulo 2^W. The sequence 2^W−1 → 0 is an in-sequence step.
- `en`=0: no register changes, and `err` is 0.
- HUNT, on `en`: `prev` ← `cnt_in`, `run` ← 1, go to VERIFY.
- VERIFY, on `en`:
  - In sequence (`cnt_in` == `prev`+1, or `restart`=1 and `cnt_in`==0): `run`++. `prev` ← `cnt_in`.
  - When `run` reaches LOCK_N, go to TRACK, `miss` ← 0, `exp_out` ← `cnt_in`+1.
  - Out of sequence: `run` ← 1 and `prev` ← `cnt_in`. No error is flagged.
- TRACK, on `en`:
  - Expected value `e` = 0 if `restart`, else `exp_out`.
  - Match (`cnt_in`==`e`): `miss` ← 0. `exp_out` ← `e`+1.
  - Mismatch: `err` pulses, `err_cnt` increments, `miss`++. `exp_out` ← `e`+1, so the expectation keeps advancing and does not resync to the bad sample.
  - When `miss` reaches LOSS_N, go to HUNT, `locked` ← 0, `exp_out` ← 0.
- `err_cnt` saturates at all-ones.
  - `clr_err` alone: `err_cnt` ← 0.
  - `clr_err` in the same cycle as a mismatch: `err_cnt` ← 1.
- Reset (any time, including mid-sequence): state HUNT, `locked`=0, `err`=0, `err_cnt`=0, `exp_out`=0, `prev`/`run`/`miss`=0.

## Timing
- All outputs are registered. They reflect the sample taken at the same rising edge and are visible for the following cycle.
- `locked` rises at the edge that samples the LOCK_N-th consecutive in-sequence value. The minimum from reset release is LOCK_N qualified samples.
- `err` is high for exactly one cycle per mismatching qualified sample. Back-to-back mismatches give back-to-back pulses.
- `locked` falls at the edge of the LOSS_N-th consecutive mismatch. That mismatch still pulses `err` and counts.
- The sample that causes loss is not reused by HUNT. HUNT restarts on the next qualified sample.
- Reset deassertion is synchronous to `clk` at system level. The first sample is taken at the first edge with `rst`=1 and `en`=1.

## Test plan
- Reset: drive `rst`=0 mid-stream while locked -> immediately `locked`=0, `err`=0, `err_cnt`=0, `exp_out`=0. After release, relock requires 4 new samples.
- Lock: `en`=1, `cnt_in`=10,11,12,13 -> `locked`=1 after the edge sampling 13, `exp_out`=14, no `err`.
- Wrap and gaps: locked, `cnt_in`=254,255 then `en`=0 for 3 cycles, then 0,1 -> no `err`, `exp_out`=2, `locked` held throughout.
- Single glitch: locked with `exp_out`=20, feed 25 then 21,22 -> one `err` pulse, `err_cnt`=1, 21 and 22 accepted, `locked` stays 1.
- Loss and relock: locked with `exp_out`=40, feed 99,99,99 -> three `err` pulses, `err_cnt`=3, `locked` falls at the third. Then 50,51,52,53 -> relock, `exp_out`=54.
- Restart/clear/saturation:
  - Locked with `exp_out`=57, `restart`=1 with `cnt_in`=0 -> no error, `exp_out`=1.
  - With ERR_W=2, 5 errors spread so lock is not lost -> `err_cnt` sticks at 3.
  - `clr_err` coincident with a mismatch -> `err_cnt`=1.
